axi4_lite_regbank: RTL and testbench
====================================

# axi4_lite_regbank

Parametrised AXI4-Lite slave register bank: `numRegs` read/write registers of `dataWidth` bits behind the `axiSlave` channel set. It accepts AW and W independently, supports byte strobes, and returns SLVERR for out-of-range addresses. It sits at the AXI4-Lite side of the APB/AXI4-Lite bridge as the local control/status target, and exposes every register as a flat output with per-register write pulses.

## Interface
- `dataWidth`, 32, data bus width; 32 or 64.
- `addrWidth`, 32, address width.
- `numRegs`, 16, number of registers; ≥1.
- `aclk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  reset; synchronous, active-high.
- `awaddr awprot awvalid awready wdata wstrb wvalid wready bresp bvalid bready araddr arprot arvalid arready rdata rresp rvalid rready`: AXI4-Lite slave channels.
  - Directions and widths are per `axiSlave`.
  - `wstrb` is `dataWidth/8` bits.
- `regs_o`  out  `numRegs*dataWidth`  register contents; reg k at `[k*dataWidth +: dataWidth]`.
- `wr_pulse_o`  out  `numRegs`  one-cycle pulse on the cycle a register is written.

## Operation
- **Decode:** word index = `addr >> log2(dataWidth/8)`.
  - The address is in range iff index < `numRegs`.
  - Low byte-offset bits are ignored.
- **Write path:** one holding slot each for AW (`aw_held`, address+prot) and W (`w_held`, data+strb).
  - `awready = !aw_held`; `wready = !w_held`.
  - AW and W may arrive in either order or in the same cycle.
- **Commit condition:** `aw_held && w_held && !bvalid`. On commit:
  - In range: update each byte i of the target register where `wstrb[i]=1`, pulse `wr_pulse_o[index]`, and set `bresp=OKAY (2'b00)`.
  - Out of range: no register change, no pulse, `bresp=SLVERR (2'b10)`.
  - Set `bvalid`, clear both held flags.
- **B channel:** `bvalid` holds until the edge where `bvalid && bready`, then clears.
  - A new AW/W may be accepted while `bvalid` is high; its commit waits for `bvalid` to clear.
- **Read path:** `arready = !rvalid`. On an AR handshake, register:
  - `rdata` = register value, or 0 if out of range;
  - `rresp` = OKAY or SLVERR;
  - `rvalid = 1`.
- **R channel:** `rvalid` holds with stable `rdata`/`rresp` until the `rready` handshake.
- **Channel independence:** read and write paths are independent; both may handshake in the same cycle.
- **Read/commit collision:** a read and a commit to the same register in the same cycle returns the pre-write value.
- **Reset values:** `awready=1`, `wready=1`, `arready=1`, `bvalid=0`, `rvalid=0`, `bresp=0`, `rresp=0`, `rdata=0`, `regs_o=0`, `wr_pulse_o=0`; held flags cleared.
  - Reset mid-transaction drops any held AW/W and any pending B/R response.
  - After reset deasserts, the master must reissue.

## Timing
- **AW and W together:** both handshake at edge T. Commit occurs at edge T+1: `regs_o`, `wr_pulse_o` and `bvalid` are all visible after T+1. Write latency is 1 cycle after the later of AW/W.
- **AW and W in different cycles:** commit occurs at the edge after the later handshake.
- **Blocked commit:** if `bvalid` is high, commit occurs at the first edge where `bvalid` is low (i.e. the edge after the B handshake).
- **Read:** AR handshake at edge T gives `rvalid`/`rdata` visible after T, so `arready=0` during the following cycle.
  - With `rready` held high, throughput is one read every 2 cycles.
- **Write throughput:** with `bready` high, one write every 2 cycles.
- **`wr_pulse_o`:** exactly one cycle wide.

## Configuration
- **`AXIL_REGBANK_PROT_CHECK_EN` defined:**
  - A write with `awprot[0]=0` (unprivileged) is treated like out-of-range: no update, no pulse, SLVERR.
  - A read with `arprot[0]=0` returns `rdata=0` with SLVERR.
- **Not defined:** `awprot`/`arprot` are ignored; all in-range accesses return OKAY.

## Test plan
- Reset, then `awaddr=0x4`, `wdata=0xDEADBEEF`, `wstrb=0xF` in the same cycle → after 1 cycle: reg1=`0xDEADBEEF`, `wr_pulse_o=0x0002` for one cycle, `bvalid=1`, `bresp=00`; then read 0x4 → `rdata=0xDEADBEEF`, `rresp=00`.
- W (`0x11223344`, `wstrb=0x5`) 3 cycles before AW (addr 0x8, reg2 previously 0) → reg2=`0x00220044`; `wready=0` until commit.
- `bready=0` for 5 cycles with a second AW/W issued → second write accepted into held slots but not committed until the B handshake; `bvalid` stays high and stable.
- Write/read to `numRegs*4` (`numRegs=16`, addr 0x40) → `bresp=10`, `rresp=10`, `rdata=0`, no register change.
- Same-cycle read of reg3 and commit of reg3 (old `0xA`, new `0xB`) → read returns `0xA`; a subsequent read returns `0xB`. With `AXIL_REGBANK_PROT_CHECK_EN`, `awprot=000` write → SLVERR, no change.
- `areset` asserted while `aw_held=1` and `rvalid=1` → next cycle all outputs at reset values; a later W alone does not commit.

Source files
------------

// File: rtl/axi4_lite_regbank.sv
// rtl/axi4_lite_regbank.sv - AXI4-Lite slave register bank with byte strobes, flat outputs and write pulses
// Optional feature macro: AXIL_REGBANK_PROT_CHECK_EN rejects unprivileged (prot[0]=0) accesses with SLVERR.
module axi4_lite_regbank #(
    parameter int dataWidth = 32,
    parameter int addrWidth = 32,
    parameter int numRegs   = 16
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [addrWidth-1:0]         awaddr,
    input  logic [2:0]                   awprot,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [dataWidth-1:0]         wdata,
    input  logic [dataWidth/8-1:0]       wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [addrWidth-1:0]         araddr,
    input  logic [2:0]                   arprot,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [dataWidth-1:0]         rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [numRegs*dataWidth-1:0] regs_o,
    output logic [numRegs-1:0]           wr_pulse_o
);
    localparam int STRB_W   = dataWidth / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                 aw_held_q, aw_held_d;
    logic [addrWidth-1:0] aw_addr_q, aw_addr_d;
    logic                 aw_priv_q, aw_priv_d;
    logic                 w_held_q, w_held_d;
    logic [dataWidth-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]    w_strb_q, w_strb_d;
    logic                 bvalid_q, bvalid_d;
    logic [1:0]           bresp_q, bresp_d;
    logic                 rvalid_q, rvalid_d;
    logic [1:0]           rresp_q, rresp_d;
    logic [dataWidth-1:0] rdata_q, rdata_d;
    logic [dataWidth-1:0] regs_q [numRegs];
    logic [dataWidth-1:0] regs_d [numRegs];
    logic [numRegs-1:0]   wr_pulse_q, wr_pulse_d;

    logic [addrWidth-1:0] aw_idx, ar_idx;
    logic                 aw_in_range, ar_in_range;
    logic                 wr_ok, rd_ok;
    logic                 aw_hs, w_hs, ar_hs, commit;
    logic [dataWidth-1:0] rd_val;
    logic                 unused_prot;

    assign aw_idx      = aw_addr_q >> ADDR_LSB;
    assign ar_idx      = araddr >> ADDR_LSB;
    assign aw_in_range = aw_idx < addrWidth'(numRegs);
    assign ar_in_range = ar_idx < addrWidth'(numRegs);

`ifdef AXIL_REGBANK_PROT_CHECK_EN
    assign wr_ok       = aw_in_range && aw_priv_q;
    assign rd_ok       = ar_in_range && arprot[0];
    assign unused_prot = &{1'b0, awprot[2:1], arprot[2:1]};
`else
    assign wr_ok       = aw_in_range;
    assign rd_ok       = ar_in_range;
    assign unused_prot = &{1'b0, awprot[2:1], arprot, aw_priv_q};
`endif

    assign aw_hs  = awvalid && !aw_held_q;
    assign w_hs   = wvalid && !w_held_q;
    assign ar_hs  = arvalid && !rvalid_q;
    // A held write waits out any unacknowledged response so B is never overwritten.
    assign commit = aw_held_q && w_held_q && !bvalid_q;

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < numRegs; k++) begin
            if (ar_idx == addrWidth'(k)) rd_val = regs_q[k];
        end
    end

    always_comb begin
        aw_held_d  = aw_held_q;
        aw_addr_d  = aw_addr_q;
        aw_priv_d  = aw_priv_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;

        if (bvalid_q && bready) bvalid_d = 1'b0;
        if (commit) begin
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            for (int k = 0; k < numRegs; k++) begin
                if (wr_ok && aw_idx == addrWidth'(k)) begin
                    wr_pulse_d[k] = 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) regs_d[k][b*8 +: 8] = w_data_q[b*8 +: 8];
                    end
                end
            end
        end
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = awaddr;
            aw_priv_d = awprot[0];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end

        // Read data comes from regs_q, so a same-cycle commit is not yet visible.
        if (rvalid_q && rready) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_ok ? rd_val : '0;
            rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held_q  <= 1'b0;
            aw_addr_q  <= '0;
            aw_priv_q  <= 1'b0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            wr_pulse_q <= '0;
            for (int k = 0; k < numRegs; k++) regs_q[k] <= '0;
        end else begin
            aw_held_q  <= aw_held_d;
            aw_addr_q  <= aw_addr_d;
            aw_priv_q  <= aw_priv_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    assign awready    = !aw_held_q;
    assign wready     = !w_held_q;
    assign bvalid     = bvalid_q;
    assign bresp      = bresp_q;
    assign arready    = !rvalid_q;
    assign rvalid     = rvalid_q;
    assign rresp      = rresp_q;
    assign rdata      = rdata_q;
    assign wr_pulse_o = wr_pulse_q;

    for (genvar k = 0; k < numRegs; k++) begin : g_flat
        assign regs_o[k*dataWidth +: dataWidth] = regs_q[k];
    end
endmodule

// File: tb/tb_axi4_lite_regbank.sv
// tb/tb_axi4_lite_regbank.sv - scoreboard bench for axi4_lite_regbank
module tb_axi4_lite_regbank;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 16;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [AW-1:0]     awaddr = '0;
    logic [2:0]        awprot = 3'b001;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DW-1:0]     wdata = '0;
    logic [DW/8-1:0]   wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [AW-1:0]     araddr = '0;
    logic [2:0]        arprot = 3'b001;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [NR*DW-1:0]  regs_o;
    logic [NR-1:0]     wr_pulse_o;

    axi4_lite_regbank #(.dataWidth(DW), .addrWidth(AW), .numRegs(NR)) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rexp_t;

    logic [1:0]    exp_b_q [$];
    rexp_t         exp_r_q [$];
    logic [DW-1:0] model [NR];
    int            checks = 0;
    int            failures = 0;

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int k = 0; k < NR; k++) f[k*DW +: DW] = model[k];
        return f;
    endfunction

    function automatic logic [1:0] exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                          input logic [3:0] s, input logic [2:0] p);
        logic [AW-1:0] idx;
        bit ok;
        idx = a >> 2;
        ok  = idx < NR;
`ifdef AXIL_REGBANK_PROT_CHECK_EN
        ok = ok && p[0];
`endif
        if (ok) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[idx[3:0]][b*8 +: 8] = d[b*8 +: 8];
        end
        return ok ? 2'b00 : 2'b10;
    endfunction

    function automatic rexp_t exp_rd(input logic [AW-1:0] a, input logic [2:0] p);
        rexp_t e;
        logic [AW-1:0] idx;
        bit ok;
        idx = a >> 2;
        ok  = idx < NR;
`ifdef AXIL_REGBANK_PROT_CHECK_EN
        ok = ok && p[0];
`endif
        e.data = ok ? model[idx[3:0]] : '0;
        e.resp = ok ? 2'b00 : 2'b10;
        return e;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input logic [2:0] p, output bit ok);
        logic a_rdy, w_rdy;
        awaddr = a; awprot = p; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 50 && (awvalid || wvalid); i++) begin
            a_rdy = awready; w_rdy = wready;
            tick();
            if (a_rdy) awvalid = 1'b0;
            if (w_rdy) wvalid = 1'b0;
        end
        ok = !(awvalid || wvalid);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic wait_b(output bit ok);
        for (int i = 0; i < 50 && !bvalid; i++) tick();
        ok = bvalid;
    endtask

    task automatic b_ack();
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [2:0] p,
                           output logic [DW-1:0] d, output logic [1:0] r, output bit ok);
        araddr = a; arprot = p; arvalid = 1'b1;
        for (int i = 0; i < 50 && !arready; i++) tick();
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 50 && !rvalid; i++) tick();
        ok = rvalid;
        d = rdata; r = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick(); tick();
        for (int k = 0; k < NR; k++) model[k] = '0;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            failures++;
            $display("FAIL reset_handshake got %b expected 11100", {awready, wready, arready, bvalid, rvalid});
        end
        checks++;
        if ({bresp, rresp, rdata, wr_pulse_o} !== '0) begin
            failures++;
            $display("FAIL reset_resp got %h expected 0", {bresp, rresp, rdata, wr_pulse_o});
        end
        checks++;
        if (regs_o !== model_flat()) begin
            failures++;
            $display("FAIL reset_regs got %h expected 0", regs_o);
        end
        areset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        logic [1:0] eb; rexp_t er; logic [DW-1:0] d; logic [1:0] r; bit ok;
        exp_b_q.push_back(exp_wr(32'h4, 32'hDEADBEEF, 4'hF, 3'b001));
        awaddr = 32'h4; awprot = 3'b001; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if ({bvalid, wr_pulse_o, regs_o[1*DW +: DW]} !== {1'b0, 16'h0, 32'h0}) begin
            failures++;
            $display("FAIL wr_early got bvalid=%b pulse=%h reg1=%h expected 0 0 0", bvalid, wr_pulse_o, regs_o[1*DW +: DW]);
        end
        tick();
        eb = exp_b_q.pop_front();
        checks++;
        if ({bvalid, bresp, wr_pulse_o, regs_o[1*DW +: DW]} !== {1'b1, eb, 16'h0002, model[1]}) begin
            failures++;
            $display("FAIL wr_commit got bvalid=%b bresp=%b pulse=%h reg1=%h expected 1 %b 0002 %h",
                     bvalid, bresp, wr_pulse_o, regs_o[1*DW +: DW], eb, model[1]);
        end
        tick();
        checks++;
        if ({bvalid, wr_pulse_o} !== {1'b1, 16'h0}) begin
            failures++;
            $display("FAIL wr_pulse_width got bvalid=%b pulse=%h expected 1 0000", bvalid, wr_pulse_o);
        end
        b_ack();
        checks++;
        if (bvalid !== 1'b0) begin
            failures++;
            $display("FAIL b_clear got %b expected 0", bvalid);
        end
        exp_r_q.push_back(exp_rd(32'h4, 3'b001));
        do_read(32'h4, 3'b001, d, r, ok);
        er = exp_r_q.pop_front();
        checks++;
        if ({ok, d, r} !== {1'b1, er.data, er.resp}) begin
            failures++;
            $display("FAIL rd_reg1 got ok=%b data=%h resp=%b expected 1 %h %b", ok, d, r, er.data, er.resp);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] eb;
        exp_b_q.push_back(exp_wr(32'h8, 32'h11223344, 4'h5, 3'b001));
        wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({wready, bvalid, regs_o[2*DW +: DW]} !== {1'b0, 1'b0, 32'h0}) begin
                failures++;
                $display("FAIL w_held_%0d got wready=%b bvalid=%b reg2=%h expected 0 0 0", i, wready, bvalid, regs_o[2*DW +: DW]);
            end
            tick();
        end
        awaddr = 32'h8; awprot = 3'b001; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        checks++;
        if ({wready, bvalid} !== 2'b00) begin
            failures++;
            $display("FAIL w_wait_commit got wready=%b bvalid=%b expected 0 0", wready, bvalid);
        end
        tick();
        eb = exp_b_q.pop_front();
        checks++;
        if ({wready, bvalid, bresp, wr_pulse_o, regs_o[2*DW +: DW]} !== {1'b1, 1'b1, eb, 16'h0004, 32'h00220044}) begin
            failures++;
            $display("FAIL strb_commit got wready=%b bvalid=%b bresp=%b pulse=%h reg2=%h expected 1 1 %b 0004 00220044",
                     wready, bvalid, bresp, wr_pulse_o, regs_o[2*DW +: DW], eb);
        end
        b_ack();
    endtask

    task automatic test_bready_stall();
        logic [1:0] eb, first; logic [DW-1:0] old6; bit ok;
        exp_b_q.push_back(exp_wr(32'h14, 32'h55AA55AA, 4'hF, 3'b001));
        do_write(32'h14, 32'h55AA55AA, 4'hF, 3'b001, ok);
        wait_b(ok);
        first = exp_b_q.pop_front();
        checks++;
        if ({ok, bresp} !== {1'b1, first}) begin
            failures++;
            $display("FAIL stall_first got ok=%b bresp=%b expected 1 %b", ok, bresp, first);
        end
        old6 = model[6];
        exp_b_q.push_back(exp_wr(32'h18, 32'h66006600, 4'hF, 3'b001));
        do_write(32'h18, 32'h66006600, 4'hF, 3'b001, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL stall_accept got %b expected 1", ok);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bvalid, bresp, awready, wready, wr_pulse_o, regs_o[6*DW +: DW]} !== {1'b1, first, 2'b00, 16'h0, old6}) begin
                failures++;
                $display("FAIL stall_hold_%0d got bvalid=%b bresp=%b awready=%b wready=%b pulse=%h reg6=%h expected 1 %b 0 0 0000 %h",
                         i, bvalid, bresp, awready, wready, wr_pulse_o, regs_o[6*DW +: DW], first, old6);
            end
            tick();
        end
        b_ack();
        checks++;
        if ({bvalid, regs_o[6*DW +: DW]} !== {1'b0, old6}) begin
            failures++;
            $display("FAIL stall_release got bvalid=%b reg6=%h expected 0 %h", bvalid, regs_o[6*DW +: DW], old6);
        end
        tick();
        eb = exp_b_q.pop_front();
        checks++;
        if ({bvalid, bresp, wr_pulse_o, regs_o[6*DW +: DW]} !== {1'b1, eb, 16'h0040, model[6]}) begin
            failures++;
            $display("FAIL stall_commit got bvalid=%b bresp=%b pulse=%h reg6=%h expected 1 %b 0040 %h",
                     bvalid, bresp, wr_pulse_o, regs_o[6*DW +: DW], eb, model[6]);
        end
        b_ack();
    endtask

    task automatic test_out_of_range();
        logic [AW-1:0] wa [3];
        logic [AW-1:0] ra [3];
        logic [1:0] eb; rexp_t er; logic [DW-1:0] d; logic [1:0] r; bit ok;
        wa = '{32'h40, 32'h3F, 32'h1000_0004};
        ra = '{32'h40, 32'h3C, 32'h1000_0004};
        for (int i = 0; i < 3; i++) begin
            exp_b_q.push_back(exp_wr(wa[i], 32'hF0E1D2C3 ^ i, 4'hF, 3'b001));
            do_write(wa[i], 32'hF0E1D2C3 ^ i, 4'hF, 3'b001, ok);
            wait_b(ok);
            eb = exp_b_q.pop_front();
            checks++;
            if ({ok, bresp, regs_o} !== {1'b1, eb, model_flat()}) begin
                failures++;
                $display("FAIL range_wr_%0d got ok=%b bresp=%b regs=%h expected 1 %b %h", i, ok, bresp, regs_o, eb, model_flat());
            end
            b_ack();
            exp_r_q.push_back(exp_rd(ra[i], 3'b001));
            do_read(ra[i], 3'b001, d, r, ok);
            er = exp_r_q.pop_front();
            checks++;
            if ({ok, d, r} !== {1'b1, er.data, er.resp}) begin
                failures++;
                $display("FAIL range_rd_%0d got ok=%b data=%h resp=%b expected 1 %h %b", i, ok, d, r, er.data, er.resp);
            end
        end
    endtask

    task automatic test_collision();
        logic [1:0] eb; rexp_t er; logic [DW-1:0] d; logic [1:0] r; bit ok;
        exp_b_q.push_back(exp_wr(32'hC, 32'hA, 4'hF, 3'b001));
        do_write(32'hC, 32'hA, 4'hF, 3'b001, ok);
        wait_b(ok);
        eb = exp_b_q.pop_front();
        b_ack();
        exp_r_q.push_back(exp_rd(32'hC, 3'b001));
        exp_b_q.push_back(exp_wr(32'hC, 32'hB, 4'hF, 3'b001));
        awaddr = 32'hC; awprot = 3'b001; wdata = 32'hB; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'hC; arprot = 3'b001; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        er = exp_r_q.pop_front();
        eb = exp_b_q.pop_front();
        checks++;
        if ({rvalid, rdata, rresp} !== {1'b1, er.data, er.resp}) begin
            failures++;
            $display("FAIL collide_rd got rvalid=%b data=%h resp=%b expected 1 %h %b", rvalid, rdata, rresp, er.data, er.resp);
        end
        checks++;
        if ({bvalid, bresp, regs_o[3*DW +: DW]} !== {1'b1, eb, model[3]}) begin
            failures++;
            $display("FAIL collide_wr got bvalid=%b bresp=%b reg3=%h expected 1 %b %h", bvalid, bresp, regs_o[3*DW +: DW], eb, model[3]);
        end
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        exp_r_q.push_back(exp_rd(32'hC, 3'b001));
        do_read(32'hC, 3'b001, d, r, ok);
        er = exp_r_q.pop_front();
        checks++;
        if ({ok, d, r} !== {1'b1, er.data, er.resp}) begin
            failures++;
            $display("FAIL collide_reread got ok=%b data=%h resp=%b expected 1 %h %b", ok, d, r, er.data, er.resp);
        end
    endtask

    task automatic test_prot();
        logic [1:0] eb; rexp_t er; logic [DW-1:0] d; logic [1:0] r; bit ok;
        exp_b_q.push_back(exp_wr(32'h10, 32'h44444444, 4'hF, 3'b000));
        do_write(32'h10, 32'h44444444, 4'hF, 3'b000, ok);
        wait_b(ok);
        eb = exp_b_q.pop_front();
        checks++;
        if ({ok, bresp, regs_o} !== {1'b1, eb, model_flat()}) begin
            failures++;
            $display("FAIL prot_wr got ok=%b bresp=%b regs=%h expected 1 %b %h", ok, bresp, regs_o, eb, model_flat());
        end
        b_ack();
        exp_r_q.push_back(exp_rd(32'h10, 3'b000));
        do_read(32'h10, 3'b000, d, r, ok);
        er = exp_r_q.pop_front();
        checks++;
        if ({ok, d, r} !== {1'b1, er.data, er.resp}) begin
            failures++;
            $display("FAIL prot_rd got ok=%b data=%h resp=%b expected 1 %h %b", ok, d, r, er.data, er.resp);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] eb; rexp_t er; logic [DW-1:0] d; logic [1:0] r; logic [DW-1:0] v; bit ok;
        bready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            exp_b_q.push_back(exp_wr(AW'((8 + i) * 4), v, 4'hF, 3'b001));
            do_write(AW'((8 + i) * 4), v, 4'hF, 3'b001, ok);
            tick();
            eb = exp_b_q.pop_front();
            checks++;
            if ({ok, bvalid, bresp, awready, regs_o} !== {1'b1, 1'b1, eb, 1'b1, model_flat()}) begin
                failures++;
                $display("FAIL b2b_wr_%0d got ok=%b bvalid=%b bresp=%b awready=%b regs=%h expected 1 1 %b 1 %h",
                         i, ok, bvalid, bresp, awready, regs_o, eb, model_flat());
            end
        end
        tick();
        bready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_r_q.push_back(exp_rd(AW'((8 + i) * 4), 3'b001));
            do_read(AW'((8 + i) * 4), 3'b001, d, r, ok);
            er = exp_r_q.pop_front();
            checks++;
            if ({ok, d, r} !== {1'b1, er.data, er.resp}) begin
                failures++;
                $display("FAIL b2b_rd_%0d got ok=%b data=%h resp=%b expected 1 %h %b", i, ok, d, r, er.data, er.resp);
            end
        end
    endtask

    task automatic test_reset_mid();
        awaddr = 32'h1C; awprot = 3'b001; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        araddr = 32'h4; arprot = 3'b001; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        checks++;
        if ({awready, rvalid} !== 2'b01) begin
            failures++;
            $display("FAIL mid_setup got awready=%b rvalid=%b expected 0 1", awready, rvalid);
        end
        areset = 1'b1;
        tick();
        areset = 1'b0;
        for (int k = 0; k < NR; k++) model[k] = '0;
        exp_b_q.delete();
        exp_r_q.delete();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, wr_pulse_o, regs_o}
            !== {5'b11100, 4'b0, 32'h0, 16'h0, model_flat()}) begin
            failures++;
            $display("FAIL mid_reset got ready=%b valid=%b rdata=%h regs=%h expected 111 00 0 0",
                     {awready, wready, arready}, {bvalid, rvalid}, rdata, regs_o);
        end
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick(); tick();
        checks++;
        if ({bvalid, wr_pulse_o, regs_o} !== {1'b0, 16'h0, model_flat()}) begin
            failures++;
            $display("FAIL mid_w_alone got bvalid=%b pulse=%h regs=%h expected 0 0 0", bvalid, wr_pulse_o, regs_o);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_w_before_aw();
        test_bready_stall();
        test_out_of_range();
        test_collision();
        test_prot();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
